// File: rtl/mem_initiator_pkg.sv
// Shared types and constants for the memory initiator.
package mem_initiator_pkg;

   localparam int          ADDR_W_DEFAULT    = 16;
   localparam int          DATA_W_DEFAULT    = 16;
   localparam int          MEM_DEPTH_DEFAULT = 101;
   localparam logic [15:0] CNT_MAX           = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/mem_initiator_sat_cnt.sv
// 16-bit debug counter that sticks at its maximum instead of wrapping.
// clr has priority over inc and is the only way back to zero.
module mem_initiator_sat_cnt
   import mem_initiator_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] r_count;
   logic [15:0] w_count_next;

   // Next-count selection: clear, saturating increment, or hold.
   always_comb begin
      w_count_next = r_count;
      if (clr) begin
         w_count_next = '0;
      end else if (inc && (r_count != CNT_MAX)) begin
         w_count_next = r_count + 16'd1;
      end
   end

   // The register is reloaded every edge so it always tracks w_count_next.
   always_ff @(posedge clk) begin
      r_count <= w_count_next;
   end

   assign count = r_count;

endmodule

// File: rtl/mem_initiator.sv
// CPU-side initiator for the single-port word memory of the multi-cycle core.
// Takes one read/write request at a time, strobes the memory for exactly one
// cycle, and returns the result over a response handshake.
// Optional feature macro: MEM_INITIATOR_RANGE_CHECK_EN -- when defined,
// addresses >= MEM_DEPTH are answered immediately with rsp_err and never
// reach the memory.
module mem_initiator
   import mem_initiator_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEFAULT,
   parameter int DATA_W    = DATA_W_DEFAULT,
   parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   state_t            r_state;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic              w_addr_ok;
   logic              w_rd_inc;
   logic              w_wr_inc;

`ifdef MEM_INITIATOR_RANGE_CHECK_EN
   // Only implemented words are forwarded to the memory.
   assign w_addr_ok = (32'(req_addr) < MEM_DEPTH);
`else
   // Every address is forwarded; the depth has no influence in this build.
   assign w_addr_ok = 1'b1 | (MEM_DEPTH > 0);
`endif

   assign req_ready = (r_state == IDLE) && !rst;

   // Counters advance on the edge that closes the one-cycle strobe.
   assign w_rd_inc = (r_state == RD);
   assign w_wr_inc = (r_state == WR);

   // Access FSM with registered strobes, address/data and response fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  if (!w_addr_ok) begin
                     // Rejected without touching the memory bus.
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (req_we) begin
                     r_state     <= WR;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= req_addr;
                     r_mem_wdata <= req_wdata;
                  end else begin
                     r_state     <= RD;
                     r_mem_read  <= 1'b1;
                     r_mem_addr  <= req_addr;
                  end
               end
            end
            RD: begin
               // Memory drove mem_rdata on the falling edge inside this cycle.
               r_state     <= RESP;
               r_mem_read  <= 1'b0;
               r_rsp_rdata <= mem_rdata;
               r_rsp_err   <= 1'b0;
               r_rsp_valid <= 1'b1;
            end
            WR: begin
               r_state     <= RESP;
               r_mem_write <= 1'b0;
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
               r_rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   mem_initiator_sat_cnt u_rd_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (w_rd_inc),
      .count (rd_cnt)
   );

   mem_initiator_sat_cnt u_wr_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (w_wr_inc),
      .count (wr_cnt)
   );

endmodule

// File: doc/mem_initiator.md
# mem_initiator

CPU-side initiator for the single-port word memory of the multi-cycle core. It accepts one load, store or fetch request at a time from the control unit over a valid/ready handshake, drives the memory strobes (`mem_read`, `mem_write`, address, write data), captures the read word, and returns a response over a second valid/ready handshake. It also keeps saturating read/write access counters for debug.

## Interface
Parameters:
- `ADDR_W`, 16: address width (word addresses).
- `DATA_W`, 16: data width, signed two's complement.
- `MEM_DEPTH`, 101: number of implemented memory words. Used only for the range check.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on the clock edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: signed write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed on the edge where `rsp_valid && rsp_ready`.
- `rsp_rdata` out DATA_W: read word. It is 0 for writes and for errors.
- `rsp_err` out 1: address out of range. Only meaningful when the range check is compiled in.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data. The memory updates it on the falling edge while `mem_read` is high.
- `rd_cnt` out 16: count of completed reads, saturating at 16'hFFFF.
- `wr_cnt` out 16: count of completed writes, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, RD, WR, RESP. All outputs are registered.
- `req_ready` = (state == IDLE) && !rst.
- On accept in IDLE:
  - Latch `req_addr` and `req_wdata`.
  - Go to RD if `req_we` == 0, or to WR if `req_we` == 1.
- RD:
  - `mem_read` = 1 and `mem_addr` = latched address for exactly one cycle.
  - At the next edge, capture `mem_rdata` into `rsp_rdata`, increment `rd_cnt`, go to RESP.
- WR:
  - `mem_write` = 1, `mem_addr`, `mem_wdata` driven for exactly one cycle. The memory commits at the closing edge.
  - At that edge, set `rsp_rdata` = 0, increment `wr_cnt`, go to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - A new request is never accepted in the same cycle as the response handshake.
- `mem_read` and `mem_write` are never high together. Both are 0 in IDLE and RESP.
- `mem_addr` and `mem_wdata` hold their last value outside RD/WR.
- Counters hold at 16'hFFFF and do not wrap.
- Data passes through bit-exact; no sign manipulation.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 0 while `rst` is high, 1 on the first cycle after.
  - `rsp_valid` = 0, `rsp_err` = 0, `mem_read` = 0, `mem_write` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `rsp_rdata` = 0, `rd_cnt` = 0, `wr_cnt` = 0.
- Latency, measured from the accept edge E:
  - The strobe is high in cycle E..E+1.
  - `rsp_valid` rises after edge E+1.
  - With `rsp_ready` held high, the handshake completes at E+2 and the next accept is possible at E+3. Throughput is one access per 3 cycles.
- Read data is sampled at the rising edge following the falling edge on which the memory drove `mem_rdata`. No extra wait state.
- Back-pressure: while `rsp_ready` = 0, the block stays in RESP indefinitely and all outputs are stable.
- Reset mid-operation: `rst` overrides every state. At that edge, strobes drop to 0, any pending response is discarded, and counters clear. An in-flight write may or may not have committed; the memory also reinitializes on `rst`.

## Configuration
- Macro: `MEM_INITIATOR_RANGE_CHECK_EN`.
- Defined:
  - A request with `req_addr` >= MEM_DEPTH never raises a strobe.
  - IDLE goes directly to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `rsp_valid` is high in cycle E+1, so latency is 1.
  - Counters are not incremented.
  - `rsp_err` clears when the next response is issued.
- Not defined:
  - All addresses are forwarded to memory.
  - `rsp_err` is tied to 0.
  - `MEM_DEPTH` is unused.

## Structure
- Package `mem_initiator_pkg`:
  - State enum (IDLE, RD, WR, RESP).
  - `ADDR_W` and `DATA_W` defaults.
  - `MEM_DEPTH_DEFAULT` = 101.
  - `CNT_MAX` = 16'hFFFF.
- One sub-module, `mem_initiator_sat_cnt`: a 16-bit saturating counter with `clr` and `inc` inputs. It is instantiated twice, for `rd_cnt` and `wr_cnt`.
- The FSM and datapath live in the top module.

## Test plan
The bench pairs the block with the team's memory model. The memory reset image has MEM[10] = 16'h00A5 and MEM[11] = 16'h00AA.
- Read addr 10, `rsp_ready` = 1 → `mem_read` high for exactly 1 cycle; `rsp_valid` at E+2 with `rsp_rdata` = 16'h00A5, `rsp_err` = 0; `rd_cnt` = 1.
- Write addr 12, data 16'hFFFB, then read addr 12 → `mem_write` high for 1 cycle; read returns 16'hFFFB (−5); `wr_cnt` = 1, `rd_cnt` = 1.
- Read addr 11 with `rsp_ready` held 0 for 5 cycles → `rsp_valid` high and `rsp_rdata` = 16'h00AA stable throughout; `req_ready` = 0; no strobes; returns to IDLE after `rsp_ready`.
- Assert `rst` during RD of addr 10 → next cycle strobes are 0, `rsp_valid` = 0, counters are 0; a subsequent read of addr 11 returns 16'h00AA.
- With `MEM_INITIATOR_RANGE_CHECK_EN` defined, read addr 200 → no strobe; `rsp_valid` at E+1 with `rsp_err` = 1, `rsp_rdata` = 0; `rd_cnt` unchanged. Without the macro, the strobe is issued and `rsp_err` = 0.
- Preload `rd_cnt` to 16'hFFFE via 65534 reads (or force), then issue 2 reads → `rd_cnt` = 16'hFFFF and holds.
